// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares the single-ported 32-word data memory between instruction fetch
// (if_*) and load/store (dm_*). There is only ever one access in flight. The
// winner's address, write enable and write data are latched onto the mem_*
// outputs. The arbiter then waits MEM_LAT cycles, captures mem_rdata and pulses
// the winner's ack for one cycle. Data has fixed priority. A starvation counter
// forces fetch to win once it has lost STARVE_MAX times in a row.
//
// Handshake (both requester ports): the requester raises req with a stable
// address, we and wdata, and holds them until it sees ack. ack is a one-cycle
// pulse, and rdata is valid only while ack is high. ack arrives in the IDLE
// cycle that follows completion. A req still high in that cycle is treated as
// a fresh request and is granted again.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   if_req/if_addr  fetch request and word address (always a read)
//   if_rdata/if_ack fetch read data and one-cycle completion pulse
//   dm_req/dm_we    data request, 1 = write / 0 = read
//   dm_addr/dm_wdata data word address and write data
//   dm_rdata/dm_ack data read data and one-cycle completion pulse
//   mem_en/mem_we   memory enable (whole access) and write enable
//   mem_addr        memory word address
//   mem_wdata       memory write data (0 on reads)
//   mem_rdata       memory read data, sampled on the completing edge
//   busy            high while an access is in flight (state ACCESS)
//   dbg_state       current FSM state (0 = IDLE, 1 = ACCESS)
//   dbg_starve_cnt  current count of consecutive fetch losses
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int WIDTH      = 32,
   parameter int MEM_SIZE   = 32,
   parameter int ADDR_W     = 5,
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [WIDTH-1:0]  if_rdata,
   output logic              if_ack,
   input  logic              dm_req,
   input  logic              dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [WIDTH-1:0]  dm_wdata,
   output logic [WIDTH-1:0]  dm_rdata,
   output logic              dm_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WIDTH-1:0]  mem_wdata,
   input  logic [WIDTH-1:0]  mem_rdata,
   output logic              busy,
   output logic              dbg_state,
   output logic [3:0]        dbg_starve_cnt
);

   // The address must cover the memory exactly, because there is no wrap or
   // range logic. The latency and starvation limits must fit their counters.
   generate
      if (MEM_SIZE != (1 << ADDR_W)) begin : g_bad_size
         $error("mem_port_arbiter: MEM_SIZE must equal 2**ADDR_W");
      end
      if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
         $error("mem_port_arbiter: MEM_LAT must be 1..7");
      end
      if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
         $error("mem_port_arbiter: STARVE_MAX must be 1..15");
      end
   endgenerate

   localparam logic [2:0] LAT  = 3'(MEM_LAT);
   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [2:0]        wait_cnt, wait_nxt;
   logic [3:0]        starve_cnt, starve_nxt;
   logic              owner_dm, owner_nxt;   // 1 = data port owns the access
   logic              grant_if, grant_dm;
   logic              done;

   logic              mem_en_nxt, mem_we_nxt, busy_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [WIDTH-1:0]  mem_wdata_nxt;
   logic              if_ack_nxt, dm_ack_nxt;
   logic [WIDTH-1:0]  if_rdata_nxt, dm_rdata_nxt;

   // The access finishes on the edge where the last latency cycle expires.
   assign done = (state == ACCESS) && (wait_cnt == 3'd1);

   // ---------------------------------------------------------------------------
   // State register: FSM, counters and all registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         starve_cnt <= '0;
         owner_dm   <= 1'b0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
         if_ack     <= 1'b0;
         dm_ack     <= 1'b0;
         if_rdata   <= '0;
         dm_rdata   <= '0;
      end else begin
         state      <= state_nxt;
         wait_cnt   <= wait_nxt;
         starve_cnt <= starve_nxt;
         owner_dm   <= owner_nxt;
         mem_en     <= mem_en_nxt;
         mem_we     <= mem_we_nxt;
         mem_addr   <= mem_addr_nxt;
         mem_wdata  <= mem_wdata_nxt;
         busy       <= busy_nxt;
         if_ack     <= if_ack_nxt;
         dm_ack     <= dm_ack_nxt;
         if_rdata   <= if_rdata_nxt;
         dm_rdata   <= dm_rdata_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic: grant decision, latency and starvation counters
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nxt  = state;
      wait_nxt   = wait_cnt;
      starve_nxt = starve_cnt;
      grant_if   = 1'b0;
      grant_dm   = 1'b0;
      case (state)
         IDLE: begin
            if (if_req || dm_req) begin
               // Data wins unless fetch has been passed over STARVE_MAX times.
               grant_if  = if_req && (!dm_req || (starve_cnt == SMAX));
               grant_dm  = !grant_if;
               state_nxt = ACCESS;
               wait_nxt  = LAT;
               if (grant_if) begin
                  starve_nxt = '0;
               end else if (if_req) begin
                  // Fetch lost a contested grant.
                  starve_nxt = (starve_cnt == SMAX) ? SMAX : starve_cnt + 4'd1;
               end
            end
         end
         ACCESS: begin
            wait_nxt = wait_cnt - 3'd1;
            if (wait_cnt == 3'd1) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output logic: next values of the registered outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      owner_nxt     = owner_dm;
      mem_en_nxt    = mem_en;
      mem_we_nxt    = mem_we;
      mem_addr_nxt  = mem_addr;
      mem_wdata_nxt = mem_wdata;
      busy_nxt      = busy;
      if_ack_nxt    = 1'b0;
      dm_ack_nxt    = 1'b0;
      if_rdata_nxt  = if_rdata;
      dm_rdata_nxt  = dm_rdata;

      if (grant_if || grant_dm) begin
         owner_nxt     = grant_dm;
         mem_en_nxt    = 1'b1;
         busy_nxt      = 1'b1;
         mem_we_nxt    = grant_dm && dm_we;
         mem_addr_nxt  = grant_dm ? dm_addr : if_addr;
         mem_wdata_nxt = (grant_dm && dm_we) ? dm_wdata : '0;
      end

      if (done) begin
         mem_en_nxt = 1'b0;
         mem_we_nxt = 1'b0;
         busy_nxt   = 1'b0;
         if (owner_dm) begin
            dm_ack_nxt = 1'b1;
            // A write returns no data, so dm_rdata keeps its last read value.
            if (!mem_we) begin
               dm_rdata_nxt = mem_rdata;
            end
         end else begin
            if_ack_nxt   = 1'b1;
            if_rdata_nxt = mem_rdata;
         end
      end
   end

   assign dbg_state      = state;
   assign dbg_starve_cnt = starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. It uses two instances: dut with
// MEM_LAT=1 and dut_3 with MEM_LAT=3. Each instance has its own behavioural
// 32-word memory with a combinational read and a write on the clock edge.
// Expected read data is pushed into exp_q when a request is driven. It is
// popped and compared when the ack arrives.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   // ---------------------------------------------------------------------------
   // Clock / reset, signals
   // ---------------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        if_req = 0, dm_req = 0, dm_we = 0;
   logic [4:0]  if_addr = 0, dm_addr = 0;
   logic [31:0] dm_wdata = 0;
   logic [31:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
   logic        if_ack, dm_ack, mem_en, mem_we, busy, dbg_state;
   logic [4:0]  mem_addr;
   logic [3:0]  dbg_starve_cnt;

   logic        if_req_3 = 0, dm_req_3 = 0, dm_we_3 = 0;
   logic [4:0]  if_addr_3 = 0, dm_addr_3 = 0;
   logic [31:0] dm_wdata_3 = 0;
   logic [31:0] if_rdata_3, dm_rdata_3, mem_wdata_3, mem_rdata_3;
   logic        if_ack_3, dm_ack_3, mem_en_3, mem_we_3, busy_3, dbg_state_3;
   logic [4:0]  mem_addr_3;
   logic [3:0]  dbg_starve_cnt_3;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] shadow[32];

   mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(3)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ack(dm_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .busy(busy), .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
   );

   mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(3)) dut_3 (
      .clk(clk), .rst(rst),
      .if_req(if_req_3), .if_addr(if_addr_3), .if_rdata(if_rdata_3), .if_ack(if_ack_3),
      .dm_req(dm_req_3), .dm_we(dm_we_3), .dm_addr(dm_addr_3), .dm_wdata(dm_wdata_3),
      .dm_rdata(dm_rdata_3), .dm_ack(dm_ack_3),
      .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3),
      .mem_wdata(mem_wdata_3), .mem_rdata(mem_rdata_3),
      .busy(busy_3), .dbg_state(dbg_state_3), .dbg_starve_cnt(dbg_starve_cnt_3)
   );

   // Behavioural memories. A bench load port preloads words while the DUT is idle.
   logic        ld_en = 0, ld_sel = 0;
   logic [4:0]  ld_addr = 0;
   logic [31:0] ld_data = 0;
   logic [31:0] mem   [32];
   logic [31:0] mem_3 [32];

   assign mem_rdata   = mem[mem_addr];
   assign mem_rdata_3 = mem_3[mem_addr_3];

   always @(posedge clk) begin
      if (ld_en && !ld_sel) mem[ld_addr] <= ld_data;
      else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
   end

   always @(posedge clk) begin
      if (ld_en && ld_sel) mem_3[ld_addr] <= ld_data;
      else if (mem_en_3 && mem_we_3) mem_3[mem_addr_3] <= mem_wdata_3;
   end

   // ---------------------------------------------------------------------------
   // Driver tasks (all return 1 time unit after a rising edge)
   // ---------------------------------------------------------------------------
   task automatic mem_load(input bit sel, input logic [4:0] a, input logic [31:0] d);
      ld_en = 1; ld_sel = sel; ld_addr = a; ld_data = d;
      @(posedge clk); #1;
      ld_en = 0;
   endtask

   task automatic drive_req(input bit is_dm, input bit we, input logic [4:0] a,
                            input logic [31:0] d);
      if (is_dm) begin
         dm_req = 1; dm_we = we; dm_addr = a; dm_wdata = d;
      end else begin
         if_req = 1; if_addr = a;
      end
   endtask

   // Wait (bounded) for the ack of one port on dut, then drop that port's req.
   task automatic wait_ack(input bit is_dm, output int edges, output logic [31:0] rd,
                           output bit got, output bit other);
      got = 0; edges = 0; other = 0; rd = '0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #1;
         edges++;
         if (is_dm ? if_ack : dm_ack) other = 1;
         if (is_dm ? dm_ack : if_ack) begin
            got = 1;
            rd  = is_dm ? dm_rdata : if_rdata;
            if (is_dm) dm_req = 0; else if_req = 0;
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   task automatic test_reset;
      rst = 1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if ({mem_en, mem_we, busy, if_ack, dm_ack, dbg_state} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {mem_en, mem_we, busy, if_ack, dm_ack, dbg_state}); end
      n_checks++; if ({if_rdata, dm_rdata, mem_wdata} !== 96'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", {if_rdata, dm_rdata, mem_wdata}); end
      n_checks++; if ({mem_addr, dbg_starve_cnt} !== 9'h0) begin n_fail++; $display("FAIL reset_addr_starve: got %h expected 0", {mem_addr, dbg_starve_cnt}); end
      rst = 0;
      @(posedge clk); #1;
      n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL idle_no_req: mem_en got %b expected 0", mem_en); end
   endtask

   task automatic test_single_read;
      int edges; logic [31:0] rd, e; bit got, oth;
      mem_load(0, 5'd5, 32'h0000_00A5);
      exp_q.push_back(32'h0000_00A5);
      drive_req(0, 0, 5'd5, 32'h0);
      @(posedge clk); #1;
      n_checks++; if ({mem_en, busy, mem_we, if_ack} !== 4'b1100) begin n_fail++; $display("FAIL single_grant: en/busy/we/ack got %b expected 1100", {mem_en, busy, mem_we, if_ack}); end
      n_checks++; if (mem_addr !== 5'd5) begin n_fail++; $display("FAIL single_addr: got %0d expected 5", mem_addr); end
      wait_ack(0, edges, rd, got, oth);
      n_checks++; if (!got || edges != 1) begin n_fail++; $display("FAIL single_latency: got ack=%0b after %0d edges expected 1", got, edges); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++; if (rd !== e) begin n_fail++; $display("FAIL single_rdata: got %h expected %h", rd, e); end
      n_checks++; if ({mem_en, busy, dm_ack, oth} !== 4'b0) begin n_fail++; $display("FAIL single_ack_cycle: en/busy/dm_ack/other got %b expected 0000", {mem_en, busy, dm_ack, oth}); end
      @(posedge clk); #1;
      n_checks++; if ({if_ack, mem_en} !== 2'b00) begin n_fail++; $display("FAIL single_one_pulse: ack/en got %b expected 00", {if_ack, mem_en}); end
   endtask

   task automatic test_reset_mid_access;
      int acks = 0, ens = 0;
      mem_load(0, 5'd9, 32'h0000_0099);
      drive_req(0, 0, 5'd9, 32'h0);
      @(posedge clk); #1;
      n_checks++; if (mem_en !== 1'b1) begin n_fail++; $display("FAIL midrst_pending: mem_en got %b expected 1", mem_en); end
      #2 rst = 1;
      #1;
      n_checks++; if ({mem_en, busy, if_ack, dm_ack} !== 4'b0) begin n_fail++; $display("FAIL midrst_ctrl: got %b expected 0000", {mem_en, busy, if_ack, dm_ack}); end
      n_checks++; if ({if_rdata, dm_rdata} !== 64'h0) begin n_fail++; $display("FAIL midrst_rdata: got %h expected 0", {if_rdata, dm_rdata}); end
      if_req = 0;
      @(posedge clk); #1;
      rst = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (if_ack || dm_ack) acks++;
         if (mem_en) ens++;
      end
      n_checks++; if (acks != 0 || ens != 0) begin n_fail++; $display("FAIL midrst_no_ack: acks %0d en_cycles %0d expected 0 0", acks, ens); end
   endtask

   task automatic test_write_read;
      int edges; logic [31:0] rd, e; bit got, oth;
      mem_load(0, 5'd3, 32'h1234_5678);
      exp_q.push_back(32'h1234_5678);
      drive_req(1, 0, 5'd3, 32'h0);
      @(posedge clk); #1;
      wait_ack(1, edges, rd, got, oth);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++; if (!got || rd !== e) begin n_fail++; $display("FAIL wr_pre_read: got %h (ack=%0b) expected %h", rd, got, e); end
      drive_req(1, 1, 5'd16, 32'hDEAD_BEEF);
      @(posedge clk); #1;
      n_checks++; if ({mem_en, mem_we, mem_addr} !== {2'b11, 5'd16}) begin n_fail++; $display("FAIL wr_grant: en/we/addr got %b/%b/%0d expected 1/1/16", mem_en, mem_we, mem_addr); end
      n_checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_wdata: got %h expected deadbeef", mem_wdata); end
      wait_ack(1, edges, rd, got, oth);
      dm_we = 0;
      n_checks++; if (!got || rd !== 32'h1234_5678) begin n_fail++; $display("FAIL wr_rdata_hold: got %h (ack=%0b) expected 12345678", rd, got); end
      n_checks++; if (if_rdata !== 32'h0 || oth) begin n_fail++; $display("FAIL wr_nonowner: if_rdata %h other_ack %0b expected 0 0", if_rdata, oth); end
      n_checks++; if (mem[16] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_memory: got %h expected deadbeef", mem[16]); end
      exp_q.push_back(32'hDEAD_BEEF);
      drive_req(1, 0, 5'd16, 32'h0);
      @(posedge clk); #1;
      n_checks++; if ({mem_we, mem_wdata} !== 33'h0) begin n_fail++; $display("FAIL rd_we_wdata: got %b/%h expected 0/0", mem_we, mem_wdata); end
      wait_ack(1, edges, rd, got, oth);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++; if (!got || rd !== e) begin n_fail++; $display("FAIL rd_after_wr: got %h (ack=%0b) expected %h", rd, got, e); end
   endtask

   // Both ports request together. Both go quiet during every ack cycle and
   // re-raise afterwards, so every grant is a fresh contested decision.
   task automatic test_contention;
      int edges; logic [31:0] rd, e; bit got, oth, win;
      bit       order  [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
      int       starve [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
      mem_load(0, 5'd1, 32'h1111_0001);
      mem_load(0, 5'd2, 32'h2222_0002);
      for (int k = 0; k < 8; k++) begin
         win = order[k];
         if_req = 1; if_addr = 5'd1;
         dm_req = 1; dm_we = 0; dm_addr = 5'd2;
         exp_q.push_back(win ? 32'h2222_0002 : 32'h1111_0001);
         @(posedge clk); #1;
         n_checks++; if (mem_addr !== (win ? 5'd2 : 5'd1)) begin n_fail++; $display("FAIL contend_winner_%0d: mem_addr got %0d expected %0d", k, mem_addr, win ? 2 : 1); end
         n_checks++; if (dbg_starve_cnt !== 4'(starve[k])) begin n_fail++; $display("FAIL contend_starve_%0d: got %0d expected %0d", k, dbg_starve_cnt, starve[k]); end
         wait_ack(win, edges, rd, got, oth);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
         n_checks++; if (!got || oth || rd !== e) begin n_fail++; $display("FAIL contend_ack_%0d: ack=%0b other=%0b rdata %h expected 1 0 %h", k, got, oth, rd, e); end
         if_req = 0; dm_req = 0;
         @(posedge clk); #1;
      end
      n_checks++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL contend_idle: mem_en got %b expected 0", mem_en); end
   endtask

   task automatic test_abandoned;
      int acks = 0, ens = 0; logic [31:0] rd = '0, e;
      mem_load(0, 5'd12, 32'h0000_C0C0);
      exp_q.push_back(32'h0000_C0C0);
      drive_req(0, 0, 5'd12, 32'h0);
      @(posedge clk); #1;
      if_req = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (if_ack) begin acks++; rd = if_rdata; end
         if (mem_en) ens++;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++; if (acks != 1 || ens != 0) begin n_fail++; $display("FAIL abandon_pulses: acks %0d en_cycles %0d expected 1 0", acks, ens); end
      n_checks++; if (rd !== e) begin n_fail++; $display("FAIL abandon_rdata: got %h expected %h", rd, e); end
   endtask

   // MEM_LAT=3 instance: busy lasts three cycles and the ack follows on the
   // fourth edge. A req held through the ack cycle is granted again after
   // exactly one idle cycle.
   task automatic test_latency3;
      int n = 0, busy_cnt = 0, ack_edge = 0; logic [31:0] rd = '0, e;
      mem_load(1, 5'd7, 32'h7777_0007);
      exp_q.push_back(32'h7777_0007);
      exp_q.push_back(32'h7777_0007);
      dm_req_3 = 1; dm_we_3 = 0; dm_addr_3 = 5'd7;
      while (ack_edge == 0 && n < 12) begin
         @(posedge clk); #1; n++;
         if (busy_3) busy_cnt++;
         if (dm_ack_3) begin ack_edge = n; rd = dm_rdata_3; end
      end
      n_checks++; if (busy_cnt != 3 || ack_edge != 4) begin n_fail++; $display("FAIL lat3_timing: busy %0d ack_edge %0d expected 3 4", busy_cnt, ack_edge); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++; if (rd !== e || busy_3 !== 1'b0 || mem_en_3 !== 1'b0) begin n_fail++; $display("FAIL lat3_ack_cycle: rdata %h busy %b en %b expected %h 0 0", rd, busy_3, mem_en_3, e); end
      @(posedge clk); #1;
      n_checks++; if (busy_3 !== 1'b1) begin n_fail++; $display("FAIL lat3_gap: busy got %b expected 1", busy_3); end
      dm_req_3 = 0;
      n = 0; ack_edge = 0;
      while (ack_edge == 0 && n < 12) begin
         @(posedge clk); #1; n++;
         if (dm_ack_3) begin ack_edge = n; rd = dm_rdata_3; end
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++; if (ack_edge != 3 || rd !== e) begin n_fail++; $display("FAIL lat3_repeat: ack_edge %0d rdata %h expected 3 %h", ack_edge, rd, e); end
      @(posedge clk); #1;
      n_checks++; if ({busy_3, dm_ack_3} !== 2'b00) begin n_fail++; $display("FAIL lat3_done: busy/ack got %b expected 00", {busy_3, dm_ack_3}); end
   endtask

   task automatic test_random;
      int edges; logic [31:0] rd, e, d; bit got, oth, is_dm, we; logic [4:0] a;
      for (int i = 0; i < 32; i++) begin
         d = $urandom;
         shadow[i] = d;
         mem_load(0, 5'(i), d);
      end
      for (int k = 0; k < 16; k++) begin
         is_dm = 1'($urandom_range(0, 1));
         we    = is_dm ? 1'($urandom_range(0, 1)) : 1'b0;
         a     = 5'($urandom_range(0, 31));
         d     = $urandom;
         if (we) shadow[a] = d; else exp_q.push_back(shadow[a]);
         drive_req(is_dm, we, a, d);
         wait_ack(is_dm, edges, rd, got, oth);
         dm_we = 0;
         n_checks++; if (!got || edges != 2 || oth) begin n_fail++; $display("FAIL rand_ack_%0d: ack=%0b edges %0d other %0b expected 1 2 0", k, got, edges, oth); end
         if (!we) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            n_checks++; if (rd !== e) begin n_fail++; $display("FAIL rand_rdata_%0d: addr %0d got %h expected %h", k, a, rd, e); end
         end
      end
   endtask

   // ---------------------------------------------------------------------------
   // Sequence and final report
   // ---------------------------------------------------------------------------
   initial begin
      test_reset();
      test_single_read();
      test_reset_mid_access();
      test_write_read();
      test_contention();
      test_abandoned();
      test_latency3();
      test_random();
      n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size()); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 32-word data memory (memory_32, pipeline step 4) between two requesters: instruction fetch (step 1) and load/store (step 4).
- Holds one outstanding access at a time and waits a fixed memory latency.
- Returns read data with a one-cycle ack pulse to the winning requester.
- Priority is fixed (data first), plus an anti-starvation counter for fetch.

Parameters:
- WIDTH, 32, data word width.
- MEM_SIZE, 32, memory depth in words.
- ADDR_W, 5, address width (log2 MEM_SIZE).
- MEM_LAT, 1, memory read latency in cycles, valid range 1..7.
- STARVE_MAX, 3, consecutive fetch losses before fetch is forced to win, valid range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- if_req  in  1  fetch request, held until if_ack.
- if_addr  in  ADDR_W  fetch word address.
- if_rdata  out  WIDTH  fetch read data, valid while if_ack=1.
- if_ack  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request, held until dm_ack.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data word address.
- dm_wdata  in  WIDTH  write data.
- dm_rdata  out  WIDTH  data read data, valid while dm_ack=1.
- dm_ack  out  1  one-cycle data completion pulse.
- mem_en  out  1  memory enable, high for the whole access.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_rdata  in  WIDTH  memory read data.
- busy  out  1  high while an access is in flight (state ACCESS).

Behaviour:
- Reset: state=IDLE, starve_cnt=0, wait_cnt=0. All outputs 0, including rdata registers. Reset takes effect immediately, asynchronously.
- States: IDLE and ACCESS. All outputs are registered.
- IDLE, no request: stay in IDLE, mem_en=0.
- IDLE, request present: at edge E0, grant one requester.
  - Latch owner, address, we and wdata into mem_* registers.
  - Set mem_en=1 and busy=1, load wait_cnt=MEM_LAT, go to ACCESS.
- Grant rule:
  - Only one requester active: it wins.
  - Both active: dm wins, unless starve_cnt==STARVE_MAX, then if wins.
- starve_cnt update at each grant:
  - if granted: clear to 0.
  - dm granted while if_req=1: increment, saturating at STARVE_MAX.
  - Otherwise: unchanged.
- ACCESS: wait_cnt decrements every edge; mem_* stay stable.
- ACCESS completion: at the edge where wait_cnt==1:
  - Capture mem_rdata into the owner's rdata register (reads only; on a write the rdata register keeps its old value).
  - Pulse the owner's ack for exactly one cycle.
  - Drop mem_en, mem_we and busy to 0; return to IDLE.
- Timing: ack is high in the cycle after edge E0+MEM_LAT.
  - Earliest next grant is the edge ending the ack cycle: one idle cycle between back-to-back accesses.
  - The ack cycle is IDLE, so a requester still holding req while its ack is high would be re-granted. Requesters must drop req in the ack cycle or accept a repeat access.
- Requests arriving during ACCESS are ignored until IDLE.
- req deasserted mid-access: the access still completes; the ack still pulses.
- Non-owner ack and rdata are never disturbed.
- if_ack and dm_ack are never high in the same cycle.
- mem_wdata=0 on reads; mem_we=1 only for dm writes. Fetch is always a read.
- Reset mid-access: access aborted, no ack issued. Any memory write already sampled by memory_32 is not undone.
- Address out of range is impossible: ADDR_W=log2(MEM_SIZE). No wrap logic.

Test Plan:
- Reset while mem_en=1 with an access pending: mem_en, busy, if_ack, dm_ack, if_rdata and dm_rdata all go to 0 immediately, asynchronously; no ack appears afterward.
- Single read, MEM_LAT=1: if_req=1, if_addr=5, memory word5=0x00A5 -> mem_en high for 1 cycle with mem_addr=5; if_ack high 2 cycles after the request edge; if_rdata=0x00A5.
- Write then read, dm_addr=16: write dm_wdata=0xDEADBEEF, then read -> mem_we=1 on the write only; read dm_ack returns dm_rdata=0xDEADBEEF; dm_rdata unchanged across the write ack.
- Contention, STARVE_MAX=3: if_req and dm_req both held high continuously, each dropped for its ack cycle only, then re-raised -> grant order dm, dm, dm, if, dm, dm, dm, if; starve_cnt sequence 1,2,3,0.
- MEM_LAT=3: dm read -> busy high 3 cycles; dm_ack 4 cycles after the grant edge; 1-cycle gap before the next grant.
- Abandoned request: if_req dropped one cycle after grant -> access completes; if_ack still pulses once; no second access.
